// File: rtl/uart_pkg.sv
// Shared types and defaults for the uart_tx request arbiter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        HOLDOFF = 2'd2,
        DRAIN   = 2'd3
    } arb_state_e;

    localparam int unsigned DEF_BITS_PER_WORD = 8;
    localparam int unsigned DEF_W_OUT         = 16;
    localparam int unsigned NUM_WORDS         = DEF_W_OUT / DEF_BITS_PER_WORD;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = IDX_W'((32'(ptr_i) + k) % N_REQ);
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer between N_REQ word requesters, round-robin,
// tracking each frame until the serializer reports idle again.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ         = 4,
    parameter int unsigned BITS_PER_WORD = DEF_BITS_PER_WORD,
    parameter int unsigned W_OUT         = 16,
    parameter int unsigned HOLDOFF_MAX   = 8,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ-1:0][W_OUT-1:0]   req_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [W_OUT-1:0]              m_data,
    output logic [$clog2(N_REQ)-1:0]      grant_id,
    output logic                          busy,
    output logic [CNT_W-1:0]              frame_count,
    output logic                          err_timeout
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned HO_W  = $clog2(HOLDOFF_MAX + 1);

    if ((W_OUT % BITS_PER_WORD) != 0 || W_OUT < BITS_PER_WORD) begin : g_bad_width
        $error("W_OUT must be a non-zero multiple of BITS_PER_WORD");
    end

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [HO_W-1:0]  ho_cnt_q, ho_cnt_d;
    logic [CNT_W-1:0] frame_q, frame_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] rr_idx;
    logic             rr_found;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .idx_o   (rr_idx),
        .found_o (rr_found)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            ptr_q    <= '0;
            ho_cnt_q <= '0;
            frame_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            ho_cnt_q <= ho_cnt_d;
            frame_q  <= frame_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        ho_cnt_d = ho_cnt_q;
        frame_d  = frame_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (m_ready && rr_found) begin
                    grant_d = rr_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // The handshake takes priority over a same-cycle withdrawal.
                if (m_ready) begin
                    frame_d  = frame_q + CNT_W'(1);
                    ptr_d    = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
                    ho_cnt_d = '0;
                    state_d  = HOLDOFF;
                end else if (!req_valid[grant_q]) begin
                    state_d = IDLE;
                end
            end
            HOLDOFF: begin
                if (!m_ready) begin
                    state_d = DRAIN;
                end else if (ho_cnt_q == HO_W'(HOLDOFF_MAX - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    ho_cnt_d = ho_cnt_q + HO_W'(1);
                end
            end
            DRAIN: begin
                if (m_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Serializer-facing handshake: the data mux is transparent only while issuing.
    assign m_valid     = (state_q == ISSUE);
    assign m_data      = m_valid ? req_data[grant_q] : '0;
    assign req_ready   = (m_valid && m_ready) ? (N_REQ'(1) << grant_q) : '0;
    assign grant_id    = grant_q;
    assign busy        = (state_q != IDLE);
    assign frame_count = frame_q;
    assign err_timeout = err_q;

endmodule
